doubled_accum: RTL and testbench

DOUBLED_ACCUM -- requirements
Module: doubled_accum

---
 rtl/doubled_accum_pkg.sv | 13 +
 rtl/doubled_accum_sat_add.sv | 21 ++
 rtl/doubled_accum.sv | 84 ++++++++
 tb/tb_doubled_accum.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/doubled_accum_pkg.sv
// Shared constants for the doubled-sample accumulator.
// State encodings and parameter defaults.
package doubled_accum_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int COUNT_DEF  = 8;
  localparam int SUM_W_DEF  = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/doubled_accum_sat_add.sv
// Saturating unsigned adder: acc + din clamped to 2^SUM_W-1.
// ovf flags that the clamp was applied.
module sat_add #(
  parameter int DATA_W = 10,
  parameter int SUM_W  = 12
) (
  input  logic [SUM_W-1:0]  acc,
  input  logic [DATA_W-1:0] din,
  output logic [SUM_W-1:0]  sum,
  output logic              ovf
);

  logic [SUM_W:0] wide;

  always_comb begin
    wide = {1'b0, acc} + (SUM_W+1)'(din);
    ovf  = wide[SUM_W];
    sum  = ovf ? {SUM_W{1'b1}} : wide[SUM_W-1:0];
  end

endmodule

// File: rtl/doubled_accum.sv
// Accumulates COUNT valid samples into a saturating sum,
// then holds the result until the consumer takes it.
module doubled_accum
  import doubled_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COUNT  = COUNT_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [SUM_W-1:0]  sum,
  output logic              ovf
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  logic [1:0]       state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic [SUM_W-1:0] add_sum;
  logic             add_ovf;

  sat_add #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_add (
    .acc (acc),
    .din (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Counter stops at LAST on the final sample instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc <= add_sum;
            if (add_ovf)
              ovf_q <= 1'b1;
            if (cnt == LAST)
              state <= S_DONE;
            else
              cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_ACCUM) || (state == S_DONE);
  assign out_valid = (state == S_DONE);
  assign sum       = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_doubled_accum.sv
// Directed self-checking bench for doubled_accum.
// Steps are driven at negedge and checked at the following negedge.
module tb_doubled_accum;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [9:0]  in_data;
  logic        out_ready;
  logic        busy;
  logic        out_valid;
  logic [11:0] sum;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  doubled_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .sum       (sum),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic b,
                         input logic v, input logic [11:0] s,
                         input logic o);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sum"}, 32'(sum), 32'(s));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask

  // One clock: drive at negedge, edge, return at next negedge.
  task automatic step(input logic s, input logic v,
                      input logic [9:0] d, input logic r);
    start     = s;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [9:0] pat [8];
    pat = '{10'd2, 10'd20, 10'd42, 10'd84, 10'd2, 10'd20, 10'd42, 10'd84};
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 1'b0, 1'b0, 12'd0, 1'b0);
    rst_n = 1'b1;

    // Basic run; first start right after reset release.
    step(1'b1, 1'b0, 10'd0, 1'b0);
    chk_out("basic_start", 1'b1, 1'b0, 12'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, pat[i], 1'b0);
    chk_out("basic_7", 1'b1, 1'b0, 12'd212, 1'b0);
    step(1'b0, 1'b1, pat[7], 1'b0);
    chk_out("basic_done", 1'b1, 1'b1, 12'd296, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    chk_out("basic_idle", 1'b0, 1'b0, 12'd296, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    chk_out("idle_ready_ignored", 1'b0, 1'b0, 12'd296, 1'b0);

    // Saturation and sticky ovf.
    step(1'b1, 1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'd800, 1'b0);
    chk_out("sat_5", 1'b1, 1'b0, 12'd4000, 1'b0);
    step(1'b0, 1'b1, 10'd800, 1'b0);
    chk_out("sat_6", 1'b1, 1'b0, 12'd4095, 1'b1);
    step(1'b0, 1'b1, 10'd800, 1'b0);
    step(1'b0, 1'b1, 10'd800, 1'b0);
    chk_out("sat_done", 1'b1, 1'b1, 12'd4095, 1'b1);
    step(1'b0, 1'b0, 10'd0, 1'b1);
    chk_out("sat_idle", 1'b0, 1'b0, 12'd4095, 1'b1);
    step(1'b1, 1'b0, 10'd0, 1'b0);
    chk_out("sat_restart", 1'b1, 1'b0, 12'd0, 1'b0);

    // Gapped input, continuing the accumulation just started.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, pat[i], 1'b0);
      step(1'b0, 1'b0, 10'd500, 1'b0);
    end
    chk_out("gap_7", 1'b1, 1'b0, 12'd212, 1'b0);
    step(1'b0, 1'b1, pat[7], 1'b0);
    chk_out("gap_done", 1'b1, 1'b1, 12'd296, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b1);

    // Start collision: sample with start must be dropped.
    step(1'b1, 1'b1, 10'd400, 1'b0);
    chk_out("coll_start", 1'b1, 1'b0, 12'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'd10, 1'b0);
    chk_out("coll_done", 1'b1, 1'b1, 12'd80, 1'b0);

    // Backpressure with start and samples ignored in DONE.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 10'd77, 1'b0);
      chk_out("bp_hold", 1'b1, 1'b1, 12'd80, 1'b0);
    end
    step(1'b0, 1'b0, 10'd0, 1'b1);
    chk_out("bp_release", 1'b0, 1'b0, 12'd80, 1'b0);

    // Asynchronous reset mid-run.
    step(1'b1, 1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'd100, 1'b0);
    chk_out("rst_pre", 1'b1, 1'b0, 12'd300, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 1'b0, 1'b0, 12'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 10'd0, 1'b0);
    chk_out("rst_restart", 1'b1, 1'b0, 12'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'd1, 1'b0);
    chk_out("rst_done", 1'b1, 1'b1, 12'd8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
